// File: rtl/byte_stream_pkg.sv
// Shared types and helpers for the 8-bit byte-stream blocks.
package byte_stream_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    // Pointer width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers, occupancy count and status flags for a circular FIFO.
module fifo_ptr_ctrl
    import byte_stream_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AW        = clog2_min1(DEPTH),
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          almost_full
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Flush discards any same-cycle pop; the top already blocks pushes then.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr      = wr_ptr_q;
    assign rd_ptr      = rd_ptr_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign almost_full = (count_q >= AFULL_C);

endmodule

// File: rtl/byte_ingress_fifo.sv
// First-word-fall-through byte FIFO with valid/ready on both sides and flush.
module byte_ingress_fifo
    import byte_stream_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AW        = clog2_min1(DEPTH),
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic [AW:0] count,
    output logic        empty,
    output logic        full,
    output logic        almost_full
);

    byte_t mem_q [DEPTH];
    byte_t mem_d [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready  = !full && !flush;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr];

    fifo_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .AFULL_LVL (AFULL_LVL)
    ) u_ptr_ctrl (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .push        (push),
        .pop         (pop),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

    // Storage is never cleared; the pointers alone decide what is valid.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr] = in_data;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_byte_ingress_fifo.sv
// Directed plus randomized self-checking bench for byte_ingress_fifo against a queue model.
module tb_byte_ingress_fifo;

    localparam int DEPTH     = 8;
    localparam int AW        = 3;
    localparam int AFULL_LVL = DEPTH - 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [AW:0] count;
    logic        empty;
    logic        full;
    logic        almost_full;

    int checks = 0;
    int failures = 0;

    logic [7:0] model_q[$];
    logic [7:0] popped_q[$];
    bit         last_push;

    byte_ingress_fifo #(
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the queue model for the current cycle.
    task automatic checkOutput();
        int n;
        n = model_q.size();
        checkVal("count", 32'(count), 32'(n));
        checkVal("empty", 32'(empty), 32'(n == 0));
        checkVal("full", 32'(full), 32'(n == DEPTH));
        checkVal("almost_full", 32'(almost_full), 32'(n >= AFULL_LVL));
        checkVal("in_ready", 32'(in_ready), 32'((n < DEPTH) && !flush));
        checkVal("out_valid", 32'(out_valid), 32'(n != 0));
        if (n != 0) checkVal("out_data", 32'(out_data), 32'(model_q[0]));
    endtask

    // One clock cycle: drive at negedge, check, advance model, pass the rising edge.
    task automatic applyStimulus(input bit iv, input logic [7:0] id, input bit ordy,
                                 input bit fl, input bit rst);
        bit do_push, do_pop;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        checkOutput();
        do_pop  = (model_q.size() != 0) && ordy;
        do_push = iv && (model_q.size() < DEPTH) && !fl;
        if (rst || fl) begin
            model_q.delete();
            do_push = 1'b0;
        end else begin
            if (do_pop) popped_q.push_back(model_q.pop_front());
            if (do_push) model_q.push_back(id);
        end
        last_push = do_push && !rst;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit         pend;
        logic [7:0] pend_data;
        logic [7:0] seq;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset then fill
        applyStimulus(0, 8'h00, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 1);
        checkVal("rst_count", 32'(count), 0);
        checkVal("rst_empty", 32'(empty), 1);
        checkVal("rst_out_valid", 32'(out_valid), 0);
        checkVal("rst_in_ready", 32'(in_ready), 1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 8'(i), 0, 0, 0);
            checkVal("fill_count", 32'(count), 32'(i));
            checkVal("fill_afull", 32'(almost_full), 32'(i >= 6));
        end
        checkVal("fill_full", 32'(full), 1);
        checkVal("fill_in_ready", 32'(in_ready), 0);
        applyStimulus(1, 8'h09, 0, 0, 0);
        applyStimulus(1, 8'h09, 0, 0, 0);
        checkVal("stall_count", 32'(count), 8);

        // Drain in order, keeping 0x09 offered until it is taken
        popped_q.delete();
        pend = 1'b1;
        for (int i = 0; i < 14 && (pend || model_q.size() != 0); i++) begin
            applyStimulus(pend, 8'h09, 1, 0, 0);
            if (last_push) pend = 1'b0;
        end
        checkVal("drain_len", 32'(popped_q.size()), 9);
        for (int i = 0; i < popped_q.size() && i < 9; i++)
            checkVal("drain_order", 32'(popped_q[i]), 32'(i + 1));
        checkVal("drain_empty", 32'(empty), 1);

        // Simultaneous push/pop at count 3
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'hA0 + 8'(i), 0, 0, 0);
        popped_q.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 8'hB0 + 8'(i), 1, 0, 0);
            checkVal("pp_count", 32'(count), 3);
        end
        checkVal("pp_first", 32'(popped_q[0]), 32'h A0);
        checkVal("pp_fourth", 32'(popped_q[3]), 32'h B0);
        while (model_q.size() != 0) applyStimulus(0, 8'h00, 1, 0, 0);

        // Pointer wrap: 20 rounds of push 3 / pop 3
        seq = 8'h10;
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 3; k++) begin
                applyStimulus(1, seq, 0, 0, 0);
                seq++;
            end
            for (int k = 0; k < 3; k++) applyStimulus(0, 8'h00, 1, 0, 0);
            checkVal("wrap_count", 32'(count), 0);
        end

        // Flush mid-operation
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'h40 + 8'(i), 0, 0, 0);
        applyStimulus(1, 8'h55, 1, 1, 0);
        checkVal("flush_count", 32'(count), 0);
        checkVal("flush_empty", 32'(empty), 1);
        applyStimulus(1, 8'h66, 0, 0, 0);
        checkVal("flush_head_valid", 32'(out_valid), 1);
        checkVal("flush_head", 32'(out_data), 32'h66);
        checkVal("flush_after_count", 32'(count), 1);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'h70 + 8'(i), 0, 0, 0);
        applyStimulus(1, 8'h77, 0, 1, 1);
        checkVal("mrst_count", 32'(count), 0);
        checkVal("mrst_out_valid", 32'(out_valid), 0);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkVal("mrst_in_ready", 32'(in_ready), 1);

        // Randomized traffic with producer holding rule
        pend = 1'b0;
        pend_data = '0;
        for (int i = 0; i < 3000; i++) begin
            bit iv, ordy, fl, rst;
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend = 1'b1;
                pend_data = 8'($urandom);
            end
            iv   = pend;
            ordy = ($urandom_range(0, 2) != 0) || (i % 200 > 150);
            fl   = ($urandom_range(0, 59) == 0);
            rst  = ($urandom_range(0, 399) == 0);
            if (i % 200 < 40) ordy = 1'b0;
            applyStimulus(iv, pend_data, ordy, fl, rst);
            if (last_push) pend = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
